// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the sequential binary-to-BCD converter.
//   state_t        : converter FSM states (IDLE, SHIFT, DONE)
//   BCD_DIGIT_W    : bits per BCD digit
//   BCD_ADJ_THRESH : digit value at or above which double-dabble adds 3
package bcd_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam int BCD_DIGIT_W    = 4;
    localparam int BCD_ADJ_THRESH = 5;
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: combinational double-dabble digit adjust (adds 3 when digit >= 5).
//   digit    : in  [3:0] working BCD digit
//   adjusted : out [3:0] digit after conditional +3
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted
);
    assign adjusted = (digit >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) ? digit + BCD_DIGIT_W'(3) : digit;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary to packed BCD converter, one bit per cycle.
//   clk       : in  system clock
//   reset     : in  asynchronous active-low reset
//   bin_in    : in  [WIDTH-1:0] value to convert, sampled when in_valid && in_ready
//   in_valid  : in  conversion request
//   in_ready  : out high in IDLE
//   bcd_out   : out [4*DIGITS-1:0] last result, digit 0 in [3:0]
//   out_valid : out one-cycle pulse when bcd_out/overflow update
//   overflow  : out last value was >= 10^DIGITS (bcd_out holds value mod 10^DIGITS)
//   blank     : out [DIGITS-1:0] leading-zero blanking, only with BIN_TO_BCD_BLANK_EN defined
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [WIDTH-1:0]                bin_in,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd_out,
    output logic                            out_valid,
    output logic                            overflow
`ifdef BIN_TO_BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]               blank
`endif
);
    localparam int BW = BCD_DIGIT_W * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] bin_sr;
    logic [BW-1:0]    bcd_w, bcd_adj;
    logic             carry;
    logic [CW-1:0]    cnt;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_add3 u_add3 (
            .digit    (bcd_w[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adjusted (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign in_ready = (state == IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? SHIFT : IDLE;
            SHIFT:   state_nx = (cnt == CW'(1)) ? DONE : SHIFT;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

`ifdef BIN_TO_BCD_BLANK_EN
    // Digit i blanks only if it and every more-significant digit are zero.
    logic [DIGITS-1:0] blank_nx;
    logic              all_zero;
    always_comb begin
        blank_nx = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            all_zero    = all_zero && (bcd_w[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            blank_nx[i] = all_zero;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bin_sr    <= '0;
            bcd_w     <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            bcd_out   <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
`ifdef BIN_TO_BCD_BLANK_EN
            blank     <= ~DIGITS'(1);
`endif
        end else begin
            state     <= state_nx;
            out_valid <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    bin_sr <= bin_in;
                    bcd_w  <= '0;
                    carry  <= 1'b0;
                    cnt    <= CW'(WIDTH);
                end
                SHIFT: begin
                    // A bit leaving the top digit means the value exceeds the digit range.
                    bcd_w  <= {bcd_adj[BW-2:0], bin_sr[WIDTH-1]};
                    bin_sr <= bin_sr << 1;
                    carry  <= carry | bcd_adj[BW-1];
                    cnt    <= cnt - CW'(1);
                end
                DONE: begin
                    bcd_out   <= bcd_w;
                    overflow  <= carry;
                    out_valid <= 1'b1;
`ifdef BIN_TO_BCD_BLANK_EN
                    blank     <= blank_nx;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: table-driven self-checking bench for bin_to_bcd_seq (WIDTH=16, DIGITS=4).
module tb_bin_to_bcd_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] bin_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] bcd_out;
    logic        out_valid;
    logic        overflow;
`ifdef BIN_TO_BCD_BLANK_EN
    logic [3:0]  blank;
`endif

    int compared = 0;
    int mismatched = 0;

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .bin_in    (bin_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_out   (bcd_out),
        .out_valid (out_valid),
        .overflow  (overflow)
`ifdef BIN_TO_BCD_BLANK_EN
        ,
        .blank     (blank)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bin;
        logic [15:0] bcd;
        logic        ovf;
        logic [3:0]  blk;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    // Single request; returns cycles counted from the request cycle to out_valid.
    task automatic convert(input logic [15:0] v, output int cyc);
        wait_ready();
        bin_in = v;
        in_valid = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            cyc++;
        end while (!out_valid && cyc < 40);
    endtask

    vec_t vecs[10];

    initial begin
        int cyc;
        int pulses;
        int last;
        logic [15:0] seen;
        vecs[0] = '{16'd1234,  16'h1234, 1'b0, 4'b0000};
        vecs[1] = '{16'd9999,  16'h9999, 1'b0, 4'b0000};
        vecs[2] = '{16'd0,     16'h0000, 1'b0, 4'b1110};
        vecs[3] = '{16'd9,     16'h0009, 1'b0, 4'b1110};
        vecs[4] = '{16'd10,    16'h0010, 1'b0, 4'b1100};
        vecs[5] = '{16'd100,   16'h0100, 1'b0, 4'b1000};
        vecs[6] = '{16'd10000, 16'h0000, 1'b1, 4'b1110};
        vecs[7] = '{16'd65535, 16'h5535, 1'b1, 4'b0000};
        vecs[8] = '{16'd42,    16'h0042, 1'b0, 4'b1100};
        vecs[9] = '{16'd65535, 16'h5535, 1'b1, 4'b0000};

        #12;
        check("rst_bcd", 32'(bcd_out), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        check("rst_ready", 32'(in_ready), 32'h1);
`ifdef BIN_TO_BCD_BLANK_EN
        check("rst_blank", 32'(blank), 32'hE);
`endif
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[k]) begin
            convert(vecs[k].bin, cyc);
            check($sformatf("latency[%0d]", k), 32'(cyc), 32'd18);
            check($sformatf("bcd[%0d]", k), 32'(bcd_out), 32'(vecs[k].bcd));
            check($sformatf("ovf[%0d]", k), 32'(overflow), 32'(vecs[k].ovf));
`ifdef BIN_TO_BCD_BLANK_EN
            check($sformatf("blank[%0d]", k), 32'(blank), 32'(vecs[k].blk));
`endif
            @(posedge clk); #1;
            check($sformatf("pulse_end[%0d]", k), 32'(out_valid), 32'd0);
            check($sformatf("hold[%0d]", k), 32'(bcd_out), 32'(vecs[k].bcd));
        end

        // Asynchronous reset in the middle of a conversion.
        wait_ready();
        bin_in = 16'd1234;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("abort_bcd", 32'(bcd_out), 32'h0);
        check("abort_ovf", 32'(overflow), 32'h0);
        check("abort_ready", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        reset = 1'b1;
        convert(16'd7, cyc);
        check("after_abort_lat", 32'(cyc), 32'd18);
        check("after_abort_bcd", 32'(bcd_out), 32'h0007);

        // A request during SHIFT is dropped.
        @(posedge clk); #1;
        wait_ready();
        bin_in = 16'd1234;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bin_in = 16'd5678;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        pulses = 0;
        seen = '0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                pulses++;
                seen = bcd_out;
            end
        end
        check("ignore_pulses", 32'(pulses), 32'd1);
        check("ignore_bcd", 32'(seen), 32'h1234);

        // Held in_valid: one result every WIDTH+2 cycles.
        wait_ready();
        bin_in = 16'd321;
        in_valid = 1'b1;
        pulses = 0;
        last = 0;
        for (int i = 1; i <= 56; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                pulses++;
                check($sformatf("b2b_interval[%0d]", pulses), 32'(i - last), 32'd18);
                check($sformatf("b2b_bcd[%0d]", pulses), 32'(bcd_out), 32'h0321);
                last = i;
            end
        end
        in_valid = 1'b0;
        check("b2b_pulses", 32'(pulses), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential double-dabble converter from binary to packed BCD.
- Sits between the core's debug/address output and the seven-segment display driver, so the 16-bit display value is shown in decimal, not hex.
- Feeds the display driver's 16-bit input. Uses one iteration per input bit, so area stays small on the FPGA target.

Parameters:
- WIDTH, 16, binary input width in bits (≥1).
- DIGITS, 4, number of BCD digits produced; the output is 4*DIGITS bits wide.

Ports:
- clk  input  1  system clock (same domain as the display driver).
- reset  input  1  asynchronous, active-low reset; asserting it clears all state immediately.
- bin_in  input  WIDTH  binary value to convert; sampled only on an accepted request.
- in_valid  input  1  conversion request.
- in_ready  output  1  high when a request will be accepted (state IDLE).
- bcd_out  output  4*DIGITS  packed BCD result; digit 0 is in bits [3:0]; holds the last completed result.
- out_valid  output  1  one-cycle pulse when bcd_out and overflow update.
- overflow  output  1  set when bin_in ≥ 10^DIGITS for the last completed conversion.

Behaviour:
- Reset values: bcd_out=0, out_valid=0, overflow=0, in_ready=1, state=IDLE, internal shift/count registers=0.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1. When in_valid=1 on a clock edge, latch bin_in into the shift register, clear the working BCD register and the sticky carry, set count=WIDTH, and go to SHIFT.
  - SHIFT: in_ready=0. Each cycle, add 3 to every working digit that is ≥5 (combinational), then shift {bcd, bin} left by 1. Any bit shifted out of the top digit sets the sticky carry. Decrement count; when count reaches 1 on this cycle's edge, go to DONE.
  - DONE: in_ready=0. Register the working digits into bcd_out and the sticky carry into overflow, pulse out_valid=1 for exactly one cycle, then go to IDLE.
- Latency: request accepted at edge N; out_valid is high in the cycle after edge N+WIDTH+1, i.e. 18 cycles for WIDTH=16. Throughput is one conversion per WIDTH+2 cycles.
- Truncation: if the value is ≥10^DIGITS, bcd_out holds value mod 10^DIGITS and overflow=1.
- in_valid while in_ready=0 (SHIFT or DONE) is ignored and not queued. The requester must hold in_valid until it sees in_ready.
- bcd_out and overflow remain stable between out_valid pulses.
- in_valid asserted in the same cycle that DONE returns to IDLE is not accepted; it is accepted in the next cycle if still held.
- Reset mid-conversion aborts the conversion; all outputs return to their reset values asynchronously.
- Width counter: $clog2(WIDTH+1) bits; it never wraps.

Optional Feature:
- Macro: BIN_TO_BCD_BLANK_EN.
- With the macro: extra output port blank [DIGITS-1:0], registered alongside bcd_out. blank[i]=1 when digit i and every more-significant digit are zero. blank[0] is always 0. Reset value is all-ones except bit 0.
- Without the macro: the port is absent and the display shows leading zeros.

Decomposition:
- Shared package bcd_pkg:
  - typedef enum for the FSM states {IDLE, SHIFT, DONE};
  - constant BCD_DIGIT_W=4;
  - constant BCD_ADJ_THRESH=5.
- Sub-module bcd_add3: combinational, 4-bit in/out, adds 3 when the input is ≥5. Instantiate it DIGITS times via generate.

Test Plan:
- Reset asserted low mid-SHIFT after 5 cycles of converting 1234 -> outputs immediately 0, in_ready=1; a new request for 7 then gives bcd_out=0x0007.
- bin_in=1234, in_valid one cycle -> out_valid exactly 18 cycles later, bcd_out=0x1234, overflow=0.
- bin_in=9999 -> bcd_out=0x9999, overflow=0.
- bin_in=0 -> bcd_out=0x0000, overflow=0.
- bin_in=65535 -> bcd_out=0x5535, overflow=1. A following request of 42 -> bcd_out=0x0042, overflow=0; with BIN_TO_BCD_BLANK_EN, blank=4'b1100.
- Request 1234, then pulse in_valid with 5678 during SHIFT -> that second request is ignored, a single out_valid pulse occurs, bcd_out=0x1234. Back-to-back held in_valid=1 -> one out_valid pulse every 18 cycles.
